spi_slave_if: RTL and testbench

Serial front end of the SPI memory slave. Deserializes 10-bit command/data words from MOSI and presents them to the memory block as `rx_data` with a one-cycle `rx_valid` strobe. When the memory returns a read byte (`tx_data`/`tx_valid`), this block serializes it back onto MISO. It sits between the SPI pins and the memory block; `clk` is the SPI serial clock.

---
 rtl/spi_slave_if.sv | 152 +++++++++++++++
 tb/tb_spi_slave_if.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if
// Serial front end of the SPI memory slave. Frames are delimited by SS_n.
// Each frame carries one 10-bit word (MSB first) that is forwarded to the
// memory block on rx_data with a one-cycle rx_valid strobe. In a read-data
// frame, the byte returned by the memory (tx_data/tx_valid) is shifted
// back out on MISO, MSB first.
//
// Ports:
//   clk       in   1   SPI serial clock, all logic on the rising edge
//   rst_n     in   1   synchronous active-low reset
//   SS_n      in   1   slave select, active low
//   MOSI      in   1   serial data in
//   MISO      out  1   serial data out (registered)
//   rx_data   out  10  received word, [9:8] command, [7:0] payload
//   rx_valid  out  1   one-cycle strobe for rx_data
//   tx_data   in   8   read byte from memory
//   tx_valid  in   1   tx_data valid, honoured only in READ_DATA
module spi_slave_if (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [9:0]  rx_shift_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  tx_shift_r;
  // tx_cnt_r: 0 = no byte yet, 1..7 = bits still to drive, 8 = byte finished
  logic [3:0]  tx_cnt_r;
  logic        rd_addr_received_r;
  logic        in_word_s;
  logic        word_done_s;
  logic        tx_start_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath control strobes
  always_comb begin
    next_state_s = state_r;
    in_word_s    = 1'b0;
    word_done_s  = 1'b0;
    tx_start_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!SS_n) next_state_s = CHK_CMD;
        else       next_state_s = IDLE;
      end
      CHK_CMD: begin
        if (SS_n)                    next_state_s = IDLE;
        else if (!MOSI)              next_state_s = WRITE;
        else if (rd_addr_received_r) next_state_s = READ_DATA;
        else                         next_state_s = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) next_state_s = IDLE;
        else      next_state_s = state_r;
        in_word_s = !SS_n;
      end
      default: next_state_s = IDLE;
    endcase
    if (in_word_s && (bit_cnt_r == 4'd9)) word_done_s = 1'b1;
    else                                  word_done_s = 1'b0;
    // A byte is only accepted once the read word is complete and no byte
    // has been shifted in this frame yet.
    if (in_word_s && (state_r == READ_DATA) && (bit_cnt_r == 4'd10) &&
        (tx_cnt_r == 4'd0) && tx_valid) begin
      tx_start_s = 1'b1;
    end else begin
      tx_start_s = 1'b0;
    end
  end

  // Receive shifter, word hand-off, read flag and MISO serializer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift_r         <= 10'd0;
      bit_cnt_r          <= 4'd0;
      tx_shift_r         <= 8'd0;
      tx_cnt_r           <= 4'd0;
      rd_addr_received_r <= 1'b0;
      rx_data            <= 10'd0;
      rx_valid           <= 1'b0;
      MISO               <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((state_r != IDLE) && SS_n) begin
        // Frame end or abort: drop partial state, keep rx_data and the flag
        bit_cnt_r  <= 4'd0;
        tx_shift_r <= 8'd0;
        tx_cnt_r   <= 4'd0;
        MISO       <= 1'b0;
      end else begin
        case (state_r)
          CHK_CMD: begin
            rx_shift_r <= {rx_shift_r[8:0], MOSI};
            bit_cnt_r  <= 4'd1;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Bits beyond the tenth are ignored until SS_n rises
            if (bit_cnt_r < 4'd10) begin
              rx_shift_r <= {rx_shift_r[8:0], MOSI};
              bit_cnt_r  <= bit_cnt_r + 4'd1;
            end
            if (word_done_s) begin
              rx_data  <= {rx_shift_r[8:0], MOSI};
              rx_valid <= 1'b1;
              if (state_r == READ_ADD)  rd_addr_received_r <= 1'b1;
              if (state_r == READ_DATA) rd_addr_received_r <= 1'b0;
            end
            if (tx_start_s) begin
              MISO       <= tx_data[7];
              tx_shift_r <= {tx_data[6:0], 1'b0};
              tx_cnt_r   <= 4'd1;
            end else if ((tx_cnt_r != 4'd0) && (tx_cnt_r < 4'd8)) begin
              MISO       <= tx_shift_r[7];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
              tx_cnt_r   <= tx_cnt_r + 4'd1;
            end else if (tx_cnt_r == 4'd8) begin
              MISO <= 1'b0;
            end
          end
          default: begin
            MISO <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHK_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic [2:0] st;
  logic       flag;

  int checks = 0;
  int errors = 0;

  spi_slave_if dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  assign st   = dut.state_r;
  assign flag = dut.rd_addr_received_r;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word; returns at the negedge after E10 with rx_valid checked.
  task automatic do_frame(input logic [9:0] w, input logic [2:0] path);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      if (i == 9) chk("state_chk_cmd", {13'd0, st}, {13'd0, S_CHK_CMD});
      if (i == 8) chk("state_path", {13'd0, st}, {13'd0, path});
      chk("rx_valid_low", {15'd0, rx_valid}, 16'd0);
      MOSI = w[i];
    end
    @(negedge clk);
    chk("rx_valid_hi", {15'd0, rx_valid}, 16'd1);
    chk("rx_data", {6'd0, rx_data}, {6'd0, w});
  endtask

  task automatic end_frame;
    @(negedge clk);
    chk("rx_valid_pulse", {15'd0, rx_valid}, 16'd0);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk("state_idle", {13'd0, st}, {13'd0, S_IDLE});
    chk("miso_idle", {15'd0, MISO}, 16'd0);
  endtask

  initial begin
    logic [7:0] byte_v;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", {13'd0, st}, {13'd0, S_IDLE});
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_rx_data", {6'd0, rx_data}, 16'd0);
    chk("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    chk("rst_flag", {15'd0, flag}, 16'd0);
    rst_n = 1'b1;

    // Write address
    do_frame(10'h0A5, S_WRITE);
    chk("wa_flag", {15'd0, flag}, 16'd0);
    chk("wa_miso", {15'd0, MISO}, 16'd0);
    end_frame();
    chk("wa_rx_hold", {6'd0, rx_data}, 16'h00A5);

    // Write data, with tx_valid held high to show it is ignored in WRITE
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    do_frame(10'h13C, S_WRITE);
    @(negedge clk);
    chk("wd_miso0", {15'd0, MISO}, 16'd0);
    @(negedge clk);
    chk("wd_miso1", {15'd0, MISO}, 16'd0);
    tx_valid = 1'b0;
    end_frame();

    // Read address then read data returning 0xC3
    do_frame(10'h207, S_READ_ADD);
    chk("ra_flag", {15'd0, flag}, 16'd1);
    end_frame();
    do_frame(10'h355, S_READ_DATA);
    chk("rd_flag", {15'd0, flag}, 16'd0);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    byte_v   = 8'hC3;
    for (int b = 7; b >= 0; b--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk("rd_miso_bit", {15'd0, MISO}, {15'd0, byte_v[b]});
    end
    @(negedge clk);
    chk("rd_miso_after", {15'd0, MISO}, 16'd0);
    end_frame();

    // Abort a READ_ADD frame after 6 bits
    @(negedge clk);
    SS_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ab_rx_valid", {15'd0, rx_valid}, 16'd0);
      MOSI = (i == 0) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    chk("ab_state_ra", {13'd0, st}, {13'd0, S_READ_ADD});
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk("ab_state_idle", {13'd0, st}, {13'd0, S_IDLE});
    chk("ab_rx_valid_end", {15'd0, rx_valid}, 16'd0);
    chk("ab_flag", {15'd0, flag}, 16'd0);
    chk("ab_rx_hold", {6'd0, rx_data}, 16'h0355);
    do_frame(10'h0A5, S_WRITE);
    end_frame();

    // Flag steering, with a late tx_valid in the read-data frame
    do_frame(10'h2AA, S_READ_ADD);
    chk("fs_flag1", {15'd0, flag}, 16'd1);
    end_frame();
    do_frame(10'h3AA, S_READ_DATA);
    chk("fs_flag0", {15'd0, flag}, 16'd0);
    tx_data = 8'h80;
    repeat (2) @(negedge clk);
    chk("fs_miso_wait", {15'd0, MISO}, 16'd0);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("fs_late_b7", {15'd0, MISO}, 16'd1);
    @(negedge clk);
    chk("fs_late_b6", {15'd0, MISO}, 16'd0);
    end_frame();

    // Mid-frame reset during bit 4 of the MISO shift
    do_frame(10'h201, S_READ_ADD);
    end_frame();
    do_frame(10'h300, S_READ_DATA);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int b = 7; b >= 4; b--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk("mr_miso_bit", {15'd0, MISO}, 16'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_miso", {15'd0, MISO}, 16'd0);
    chk("mr_state", {13'd0, st}, {13'd0, S_IDLE});
    chk("mr_rx_data", {6'd0, rx_data}, 16'd0);
    chk("mr_flag", {15'd0, flag}, 16'd0);
    rst_n = 1'b1;
    SS_n  = 1'b1;
    do_frame(10'h0A5, S_WRITE);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
